// File: rtl/alu_operand_stage_if.sv
// Handshake and operand bus around the ID/EX operand stage: the ID-side request,
// the MEM/WB forwarding taps and the EX-side operand outputs.
interface alu_operand_stage_if #(
  parameter int N = 64
);
  // ID -> stage
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_rd_data1;
  logic [N-1:0] in_rd_data2;
  logic [N-1:0] in_imm;
  logic [4:0]   in_rs1;
  logic [4:0]   in_rs2;
  logic [4:0]   in_rd;
  logic         in_alu_src;
  logic [3:0]   in_alu_control;
  logic         in_reg_write;
  logic         flush;

  // forwarding taps from later stages
  logic         mem_reg_write;
  logic         mem_is_load;
  logic [4:0]   mem_rd;
  logic [N-1:0] mem_result;
  logic         wb_reg_write;
  logic [4:0]   wb_rd;
  logic [N-1:0] wb_result;

  // stage -> EX
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] alu_a;
  logic [N-1:0] alu_b;
  logic [3:0]   alu_control;
  logic [4:0]   out_rd;
  logic         out_reg_write;
  logic [N-1:0] out_store_data;

  modport master (
    output in_valid, in_rd_data1, in_rd_data2, in_imm, in_rs1, in_rs2, in_rd,
           in_alu_src, in_alu_control, in_reg_write, flush,
           mem_reg_write, mem_is_load, mem_rd, mem_result,
           wb_reg_write, wb_rd, wb_result, out_ready,
    input  in_ready, out_valid, alu_a, alu_b, alu_control, out_rd,
           out_reg_write, out_store_data
  );

  modport slave (
    input  in_valid, in_rd_data1, in_rd_data2, in_imm, in_rs1, in_rs2, in_rd,
           in_alu_src, in_alu_control, in_reg_write, flush,
           mem_reg_write, mem_is_load, mem_rd, mem_result,
           wb_reg_write, wb_rd, wb_result, out_ready,
    output in_ready, out_valid, alu_a, alu_b, alu_control, out_rd,
           out_reg_write, out_store_data
  );
endinterface

// File: rtl/alu_operand_stage.sv
// ID/EX operand stage: holds one decoded instruction, forwards from MEM/WB,
// stalls on load-use and supplies ALU operands, store data and rd info to EX.
module alu_operand_stage #(
  parameter int N        = 64,
  parameter int REG_ZERO = 31
) (
  input  logic                 clk,
  input  logic                 reset_n,
  alu_operand_stage_if.slave   bus
);

  // Handshake: a transfer happens on an edge where valid & ready are both high;
  // valid never depends on ready, and outputs hold while valid & !ready.
  localparam logic [4:0] ZERO_IDX = 5'(REG_ZERO);

  logic         held_valid_q, held_valid_d;
  logic [4:0]   rs1_q, rs1_d;
  logic [4:0]   rs2_q, rs2_d;
  logic [4:0]   rd_q, rd_d;
  logic [N-1:0] data1_q, data1_d;
  logic [N-1:0] data2_q, data2_d;
  logic [N-1:0] imm_q, imm_d;
  logic         alu_src_q, alu_src_d;
  logic [3:0]   ctrl_q, ctrl_d;
  logic         reg_write_q, reg_write_d;

  logic wb_cap1, wb_cap2, wb_held1, wb_held2;
  logic mem_fwd1, mem_fwd2;
  logic load_hit1, load_hit2, load_use;
  logic out_valid, capture, consume;
  logic [N-1:0] sel1, sel2;

  always_comb begin
    wb_cap1   = bus.wb_reg_write && (bus.wb_rd == bus.in_rs1) && (bus.in_rs1 != ZERO_IDX);
    wb_cap2   = bus.wb_reg_write && (bus.wb_rd == bus.in_rs2) && (bus.in_rs2 != ZERO_IDX);
    wb_held1  = bus.wb_reg_write && (bus.wb_rd == rs1_q) && (rs1_q != ZERO_IDX);
    wb_held2  = bus.wb_reg_write && (bus.wb_rd == rs2_q) && (rs2_q != ZERO_IDX);
    mem_fwd1  = bus.mem_reg_write && !bus.mem_is_load && (bus.mem_rd == rs1_q) && (rs1_q != ZERO_IDX);
    mem_fwd2  = bus.mem_reg_write && !bus.mem_is_load && (bus.mem_rd == rs2_q) && (rs2_q != ZERO_IDX);
    load_hit1 = (bus.mem_rd == rs1_q) && (rs1_q != ZERO_IDX);
    load_hit2 = (bus.mem_rd == rs2_q) && (rs2_q != ZERO_IDX);
    load_use  = held_valid_q && bus.mem_reg_write && bus.mem_is_load && (load_hit1 || load_hit2);
  end

  assign out_valid    = held_valid_q && !load_use;
  assign consume      = out_valid && bus.out_ready;
  assign bus.in_ready = !held_valid_q || consume;
  assign capture      = bus.in_valid && bus.in_ready && !bus.flush;

  assign sel1 = mem_fwd1 ? bus.mem_result : data1_q;
  assign sel2 = mem_fwd2 ? bus.mem_result : data2_q;

  assign bus.out_valid      = out_valid;
  assign bus.alu_a          = sel1;
  assign bus.alu_b          = alu_src_q ? imm_q : sel2;
  assign bus.out_store_data = sel2;
  assign bus.alu_control    = ctrl_q;
  assign bus.out_rd         = rd_q;
  assign bus.out_reg_write  = reg_write_q;

  always_comb begin
    held_valid_d = held_valid_q;
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    rd_d         = rd_q;
    data1_d      = data1_q;
    data2_d      = data2_q;
    imm_d        = imm_q;
    alu_src_d    = alu_src_q;
    ctrl_d       = ctrl_q;
    reg_write_d  = reg_write_q;
    if (bus.flush) begin
      held_valid_d = 1'b0;
    end else if (capture) begin
      held_valid_d = 1'b1;
      rs1_d        = bus.in_rs1;
      rs2_d        = bus.in_rs2;
      rd_d         = bus.in_rd;
      data1_d      = wb_cap1 ? bus.wb_result : bus.in_rd_data1;
      data2_d      = wb_cap2 ? bus.wb_result : bus.in_rd_data2;
      imm_d        = bus.in_imm;
      alu_src_d    = bus.in_alu_src;
      ctrl_d       = bus.in_alu_control;
      reg_write_d  = bus.in_reg_write;
    end else if (consume) begin
      held_valid_d = 1'b0;
    end else if (held_valid_q) begin
      // A waiting instruction keeps absorbing WB writes so that a value seen
      // earlier via MEM forwarding is still correct after the producer retires.
      if (wb_held1) data1_d = bus.wb_result;
      if (wb_held2) data2_d = bus.wb_result;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      held_valid_q <= 1'b0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rd_q         <= '0;
      data1_q      <= '0;
      data2_q      <= '0;
      imm_q        <= '0;
      alu_src_q    <= 1'b0;
      ctrl_q       <= '0;
      reg_write_q  <= 1'b0;
    end else begin
      held_valid_q <= held_valid_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      rd_q         <= rd_d;
      data1_q      <= data1_d;
      data2_q      <= data2_d;
      imm_q        <= imm_d;
      alu_src_q    <= alu_src_d;
      ctrl_q       <= ctrl_d;
      reg_write_q  <= reg_write_d;
    end
  end

endmodule
